// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, 8N1 framing constants and baud divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam logic UART_IDLE = 1'b1;
  localparam logic UART_START = 1'b0;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick divider with phase-aligning clear
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear of the divider count
//   tick  : one-cycle pulse every DIV cycles
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling and a valid/ready holding register
//   user_clock    : clock, rising edge
//   rst           : asynchronous active-low reset
//   usb_rs232_rxd : asynchronous serial line, idles high
//   rx_data       : last received byte
//   rx_valid      : rx_data holds an unconsumed byte
//   rx_ready      : consumer accepts rx_data when rx_valid && rx_ready
//   frame_err     : one-cycle pulse, stop bit sampled low
//   overrun       : one-cycle pulse, unconsumed byte overwritten
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 user_clock,
  input  logic                 rst,
  input  logic                 usb_rs232_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  logic [1:0] sync;
  logic rxd_s, tick, clr, sample;
  state_t state;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] shift;
  assign rxd_s = sync[1];
  // restart the divider on the start edge so every sample lands mid-bit
  assign clr = state == IDLE && rxd_s == UART_START;
  // first sample is half a bit in, every later one a full bit apart
  assign sample = tick && tcnt == (state == START ? T_MID : T_END);
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (user_clock),
    .rst_n(rst),
    .clr  (clr),
    .tick (tick)
  );
  always_ff @(posedge user_clock or negedge rst)
    if (!rst) begin
      sync      <= {2{UART_IDLE}};
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync      <= {sync[0], usb_rs232_rxd};
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (tick) tcnt <= sample ? '0 : tcnt + TW'(1);
      case (state)
        IDLE:
          if (clr) begin
            state <= START;
            tcnt  <= '0;
            bcnt  <= '0;
          end
        START: if (sample) state <= rxd_s == UART_START ? DATA : IDLE;
        DATA:
          if (sample) begin
            shift <= {rxd_s, shift[DATA_BITS-1:1]};
            bcnt  <= bcnt + BW'(1);
            if (bcnt == B_LAST) state <= STOP;
          end
        STOP:
          if (sample) begin
            if (rxd_s == UART_IDLE) begin
              // a same-cycle consume frees the register, so only a stalled byte is lost
              state    <= IDLE;
              rx_data  <= shift;
              rx_valid <= 1'b1;
              overrun  <= rx_valid && !rx_ready;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        // hold off until the line returns high so a break cannot retrigger
        BREAK: if (rxd_s == UART_IDLE) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD = 781_250;
  localparam int BT = 1_000_000_000 / BAUD;
  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data, mon_exp;
  logic rx_valid, frame_err, overrun;
  int n_cmp = 0, n_fail = 0, hs_cnt = 0, ovr_cnt = 0, ferr_cnt = 0, vhi_cnt = 0;
  logic [7:0] q[$];

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .user_clock   (clk),
    .rst          (rst_n),
    .usb_rs232_rxd(rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #10 clk = ~clk;

  always @(negedge clk)
    if (rst_n) begin
      if (rx_valid) vhi_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err) ferr_cnt++;
      if (rx_valid && rx_ready) begin
        hs_cnt++;
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL hs_data: got %h, required no byte (scoreboard empty)", rx_data);
        end else begin
          mon_exp = q.pop_front();
          if (rx_data !== mon_exp) begin
            n_fail++;
            $display("FAIL hs_data: got %h, required %h", rx_data, mon_exp);
          end
        end
      end
    end

  task automatic send(input logic [7:0] d, input int bt, input int stop_low);
    rxd = 1'b0;
    #bt;
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #bt;
    end
    if (stop_low > 0) begin
      rxd = 1'b0;
      #(bt * stop_low);
    end
    rxd = 1'b1;
    #bt;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 rx_ready = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h, required 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", rx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_ferr: got %b, required 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b, required 0", overrun); end
    #3 rst_n = 1'b1;
    #(2 * BT);
  endtask

  task automatic test_basic();
    int h0, v0, f0, o0;
    set_ready(1'b1);
    h0 = hs_cnt; v0 = vhi_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    q.push_back(8'h55);
    send(8'h55, BT, 0);
    #(2 * BT);
    n_cmp++; if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL basic_hs: got %0d, required 1", hs_cnt - h0); end
    n_cmp++; if (vhi_cnt - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d, required 1", vhi_cnt - v0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL basic_ferr: got %0d, required 0", ferr_cnt - f0); end
    n_cmp++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL basic_ovr: got %0d, required 0", ovr_cnt - o0); end
  endtask

  task automatic test_frame_err();
    int h0, v0, f0;
    h0 = hs_cnt; v0 = vhi_cnt; f0 = ferr_cnt;
    send(8'hA5, BT, 2);
    #BT;
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d, required 1", ferr_cnt - f0); end
    n_cmp++; if (vhi_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d, required 0", vhi_cnt - v0); end
    q.push_back(8'h3C);
    send(8'h3C, BT, 0);
    #(2 * BT);
    n_cmp++; if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL ferr_next_hs: got %0d, required 1", hs_cnt - h0); end
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_next_ferr: got %0d, required 1", ferr_cnt - f0); end
  endtask

  task automatic test_glitch();
    int h0, f0;
    h0 = hs_cnt; f0 = ferr_cnt;
    rxd = 1'b0;
    #400;
    rxd = 1'b1;
    #(2 * BT);
    n_cmp++; if (hs_cnt - h0 !== 0) begin n_fail++; $display("FAIL glitch_hs: got %0d, required 0", hs_cnt - h0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d, required 0", ferr_cnt - f0); end
    n_cmp++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d, required %0d", dut.state, IDLE); end
  endtask

  task automatic test_overrun();
    int h0, o0;
    set_ready(1'b0);
    h0 = hs_cnt; o0 = ovr_cnt;
    q.push_back(8'h11);
    send(8'h11, BT, 0);
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b, required 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_first_data: got %h, required 11", rx_data); end
    void'(q.pop_front());
    q.push_back(8'h22);
    send(8'h22, BT, 0);
    n_cmp++; if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d, required 1", ovr_cnt - o0); end
    n_cmp++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr_data: got %h, required 22", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b, required 1", rx_valid); end
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume_valid: got %b, required 0", rx_valid); end
    n_cmp++; if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL ovr_hs: got %0d, required 1", hs_cnt - h0); end
  endtask

  task automatic test_reset_abort();
    int h0, f0, o0;
    set_ready(1'b1);
    h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    rxd = 1'b0;
    #(5 * BT);
    rxd = 1'b1;
    #(BT / 2);
    rst_n = 1'b0;
    #100;
    rst_n = 1'b1;
    #(BT / 2 + 4 * BT);
    n_cmp++; if (hs_cnt - h0 !== 0) begin n_fail++; $display("FAIL abort_hs: got %0d, required 0", hs_cnt - h0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL abort_ferr: got %0d, required 0", ferr_cnt - f0); end
    n_cmp++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL abort_ovr: got %0d, required 0", ovr_cnt - o0); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b, required 0", rx_valid); end
    q.push_back(8'h81);
    send(8'h81, BT, 0);
    #(2 * BT);
    n_cmp++; if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL abort_next_hs: got %0d, required 1", hs_cnt - h0); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic r, mdl_valid, eo;
    int bt, o0;
    mdl_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      d = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 2) != 0;
      bt = BT + int'($urandom_range(0, 50)) - 25;
      set_ready(r);
      eo = mdl_valid && !r;
      if (eo) void'(q.pop_front());
      q.push_back(d);
      o0 = ovr_cnt;
      send(d, bt, 0);
      n_cmp++;
      if (ovr_cnt - o0 !== int'(eo)) begin
        n_fail++;
        $display("FAIL rand_ovr[%0d]: got %0d, required %0d", k, ovr_cnt - o0, eo);
      end
      mdl_valid = !r;
      #($urandom_range(0, BT));
    end
    set_ready(1'b1);
    #BT;
    n_cmp++; if (q.size() !== 0) begin n_fail++; $display("FAIL rand_drain: got %0d left, required 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
